// File: rtl/temphumi_pkg.sv
// temphumi_pkg: shared state, byte-index and BCD constants for temphumi_bcd.
package temphumi_pkg;

    localparam int BCD_W = 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] B_TEMP_INT = 2'd0;
    localparam logic [1:0] B_TEMP_DEC = 2'd1;
    localparam logic [1:0] B_HUMI_INT = 2'd2;
    localparam logic [1:0] B_HUMI_DEC = 2'd3;

    // Byte 0 is the most significant byte of the packed reading.
    function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] i);
        return v[8*(3-int'(i)) +: 8];
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/temphumi_bcd_step.sv
// bcd_dd_step: one double-dabble iteration (add-3 correction, then shift {bcd,bin} left by one).
module bcd_dd_step
    import temphumi_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    input  logic [7:0]       bin,
    output logic [BCD_W-1:0] bcd_o,
    output logic [7:0]       bin_o
);

    logic [BCD_W-2:0] adj;

    // The hundreds digit's top bit is shifted out, so only its low 3 bits are kept.
    always_comb begin
        adj[10:8] = bcd[10:8] + (bcd[11:8] >= 4'd5 ? 3'd3 : 3'd0);
        adj[7:4]  = add3(bcd[7:4]);
        adj[3:0]  = add3(bcd[3:0]);
        {bcd_o, bin_o} = {adj, bin, 1'b0};
    end

endmodule

// File: rtl/temphumi_bcd.sv
// temphumi_bcd: stable-reading detector plus sequential double-dabble BCD converter for DHT11 data.
// Optional over-temperature alarm enabled with `define TEMPHUMI_ALARM_EN.
module temphumi_bcd
    import temphumi_pkg::*;
#(
    parameter int STABLE_CNT = 1
`ifdef TEMPHUMI_ALARM_EN
    ,
    parameter logic [7:0] TEMP_HI   = 8'd35,
    parameter logic [7:0] TEMP_HYST = 8'd2
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      TempHumi,
    output logic [BCD_W-1:0] temp_int_bcd,
    output logic [BCD_W-1:0] temp_dec_bcd,
    output logic [BCD_W-1:0] humi_int_bcd,
    output logic [BCD_W-1:0] humi_dec_bcd,
    output logic             bcd_valid,
    output logic             busy,
    output logic             temp_alarm
);

    state_t           state, state_nx;
    logic [31:0]      in_r, accepted;
    logic [3:0]       stab_cnt;
    logic [4:0]       cnt;
    logic [BCD_W-1:0] scr_bcd, hold_ti, hold_td, hold_hi;
    logic [7:0]       scr_bin;
    logic [BCD_W-1:0] st_bcd_i, st_bcd_o;
    logic [7:0]       st_bin_i, st_bin_o;
    logic             accept, last;

    assign accept = state == S_IDLE && stab_cnt == 4'(STABLE_CNT);
    assign last   = state == S_CONV && &cnt;

    // Scratch is implicitly cleared at each byte start by muxing in zero and the fresh byte.
    assign st_bcd_i = cnt[2:0] == 3'd0 ? '0 : scr_bcd;
    assign st_bin_i = cnt[2:0] == 3'd0 ? byte_sel(accepted, cnt[4:3]) : scr_bin;

    bcd_dd_step u_step (
        .bcd   (st_bcd_i),
        .bin   (st_bin_i),
        .bcd_o (st_bcd_o),
        .bin_o (st_bin_o)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;

    always_comb
        state_nx = state == S_IDLE ? (accept ? S_CONV : S_IDLE) :
                   state == S_CONV ? (&cnt ? S_DONE : S_CONV) : S_IDLE;

    always_comb begin
        busy      = state != S_IDLE;
        bcd_valid = state == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_r     <= '0;
            stab_cnt <= '0;
            accepted <= '0;
        end else begin
            in_r     <= TempHumi;
            stab_cnt <= (TempHumi == in_r && in_r != accepted) ?
                        (stab_cnt == 4'(STABLE_CNT) ? stab_cnt : stab_cnt + 4'd1) : 4'd0;
            if (accept) accepted <= in_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            scr_bcd      <= '0;
            scr_bin      <= '0;
            hold_ti      <= '0;
            hold_td      <= '0;
            hold_hi      <= '0;
            temp_int_bcd <= '0;
            temp_dec_bcd <= '0;
            humi_int_bcd <= '0;
            humi_dec_bcd <= '0;
        end else if (state == S_CONV) begin
            cnt     <= cnt + 5'd1;
            scr_bcd <= st_bcd_o;
            scr_bin <= st_bin_o;
            if (cnt == {B_TEMP_INT, 3'd7}) hold_ti <= st_bcd_o;
            if (cnt == {B_TEMP_DEC, 3'd7}) hold_td <= st_bcd_o;
            if (cnt == {B_HUMI_INT, 3'd7}) hold_hi <= st_bcd_o;
            // All four outputs move together on the final shift, alongside the valid strobe.
            if (cnt == {B_HUMI_DEC, 3'd7}) begin
                temp_int_bcd <= hold_ti;
                temp_dec_bcd <= hold_td;
                humi_int_bcd <= hold_hi;
                humi_dec_bcd <= st_bcd_o;
            end
        end
    end

`ifdef TEMPHUMI_ALARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) temp_alarm <= 1'b0;
        else if (last) begin
            if (accepted[31:24] >= TEMP_HI) temp_alarm <= 1'b1;
            else if (accepted[31:24] <= TEMP_HI - TEMP_HYST) temp_alarm <= 1'b0;
        end
    end
`else
    assign temp_alarm = 1'b0;
    logic unused_last;
    assign unused_last = last;
`endif

endmodule
